// File: rtl/apb_pad_reader_pkg.sv
// Shared register map, bit positions and frame FSM encoding for the pad reader.
// No logic; imported by the engine and the APB top level.
package apb_pad_reader_pkg;

   // Word indices decoded from PADDR[7:2]
   localparam logic [5:0] IDX_CTRL   = 6'd0;
   localparam logic [5:0] IDX_STATUS = 6'd1;
   localparam logic [5:0] IDX_PERIOD = 6'd2;
   localparam logic [5:0] IDX_DATA0  = 6'd4;

   localparam int CTRL_AUTO    = 0;
   localparam int CTRL_START   = 1;
   localparam int CTRL_IRQ_EN  = 2;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_DONE    = 1;
   localparam int STAT_OVERRUN = 2;

   typedef enum logic [2:0] {
      IDLE,
      LATCH,
      SHIFT_LO,
      SHIFT_HI,
      DONE
   } frame_state_t;

endpackage

// File: rtl/apb_pad_reader_if.sv
// APB3 completer-side bundle for the pad reader; PREADY is tied high by the slave.
// Master drives the request, slave returns read data and error.
interface apb_pad_reader_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_pad_reader_frame_engine.sv
// Frame sequencer: latch strobe, BITS sclk pulses, LSB-first capture on each channel.
// Trigger to commit: LATCH_CYC + 2*BITS*CLK_DIV + 1 cycles; triggers while busy are ignored.
module pad_frame_engine
   import apb_pad_reader_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int BITS      = 8,
   parameter int CLK_DIV   = 600,
   parameter int LATCH_CYC = 1200,
   parameter int INVERT    = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_trigger,
   input  logic [NUM_CH-1:0]              i_data,
   output logic                           o_poll,
   output logic                           o_sclk,
   output logic                           o_commit,
   output logic                           o_busy,
   output logic [NUM_CH-1:0][BITS-1:0]    o_shift
);

   localparam int MAXC = (LATCH_CYC > CLK_DIV) ? LATCH_CYC : CLK_DIV;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int KW   = $clog2(BITS + 1);
   localparam logic [CW-1:0] LAT_LAST = CW'(LATCH_CYC - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [KW-1:0] BIT_LAST = KW'(BITS - 1);
   localparam logic          INV      = (INVERT != 0);

   frame_state_t                  r_state;
   frame_state_t                  w_next;
   logic [CW-1:0]                 r_cnt;
   logic [KW-1:0]                 r_bit;
   logic [NUM_CH-1:0][BITS-1:0]   r_shift;
   logic                          w_phase_end;

   always_comb begin
      w_phase_end = 1'b0;
      case (r_state)
         LATCH:              w_phase_end = (r_cnt == LAT_LAST);
         SHIFT_LO, SHIFT_HI: w_phase_end = (r_cnt == DIV_LAST);
         default:            w_phase_end = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (i_trigger)   w_next = LATCH;
         LATCH:    if (w_phase_end) w_next = SHIFT_LO;
         SHIFT_LO: if (w_phase_end) w_next = SHIFT_HI;
         SHIFT_HI: if (w_phase_end) w_next = (r_bit == BIT_LAST) ? DONE : SHIFT_LO;
         DONE:                      w_next = IDLE;
         default:                   w_next = IDLE;
      endcase
   end

   always_comb begin
      o_poll   = (r_state == LATCH);
      o_sclk   = (r_state == SHIFT_HI);
      o_commit = (r_state == DONE);
      o_busy   = (r_state != IDLE);
   end

   // Phase counter restarts at every state change; bit k advances after each high phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
      end else begin
         if (w_phase_end || r_state == IDLE || r_state == DONE) r_cnt <= '0;
         else                                                  r_cnt <= r_cnt + 1'b1;

         if (r_state == IDLE)                      r_bit <= '0;
         else if (r_state == SHIFT_HI && w_phase_end) r_bit <= r_bit + 1'b1;

         if (r_state == SHIFT_LO && w_phase_end) begin
            for (int c = 0; c < NUM_CH; c++) begin
               for (int b = 0; b < BITS; b++) begin
                  if (r_bit == KW'(b)) r_shift[c][b] <= i_data[c] ^ INV;
               end
            end
         end
      end
   end

   assign o_shift = r_shift;

endmodule

// File: rtl/apb_pad_reader.sv
// APB3 front end for the pad frame engine: CTRL/STATUS/PERIOD, auto-poll timer, DATA snapshot.
// Zero wait states (PREADY=1); DATA registers change only on a frame commit.
module apb_pad_reader
   import apb_pad_reader_pkg::*;
#(
   parameter int          NUM_CH       = 2,
   parameter int          BITS         = 8,
   parameter int          CLK_DIV      = 600,
   parameter int          LATCH_CYC    = 1200,
   parameter int          INVERT       = 1,
   parameter logic [23:0] POLL_DEFAULT = 24'd400000
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   apb_pad_reader_if.slave     bus,
   input  logic [NUM_CH-1:0]   data,
   output logic                poll,
   output logic                sclk,
   output logic                ready,
   output logic                irq,
   output logic [BITS-1:0]     buttonData
);

   logic [5:0]                  w_idx;
   logic                        w_acc;
   logic                        w_wr;
   logic                        w_wr_ctrl;
   logic                        w_wr_status;
   logic                        w_wr_period;
   logic                        w_start;
   logic                        w_tick;
   logic                        w_commit;
   logic                        w_busy;
   logic                        w_valid;
   logic [31:0]                 w_rdata;
   logic                        w_unused;
   logic [NUM_CH-1:0][BITS-1:0] w_shift;

   logic                        r_auto;
   logic                        r_irq_en;
   logic                        r_done;
   logic                        r_ovr;
   logic [23:0]                 r_period;
   logic [23:0]                 r_pcnt;
   logic [NUM_CH-1:0][BITS-1:0] r_data;

   assign w_idx       = bus.PADDR[7:2];
   assign w_acc       = bus.PSEL & bus.PENABLE;
   assign w_wr        = w_acc & bus.PWRITE;
   assign w_wr_ctrl   = w_wr && (w_idx == IDX_CTRL);
   assign w_wr_status = w_wr && (w_idx == IDX_STATUS);
   assign w_wr_period = w_wr && (w_idx == IDX_PERIOD);
   assign w_start     = w_wr_ctrl & bus.PWDATA[CTRL_START];
   assign w_unused    = ^{bus.PADDR[31:8], bus.PADDR[1:0], bus.PWDATA[31:24]};

   // A PERIOD write restarts the interval, so it cannot also fire a tick
   assign w_tick = r_auto && (r_period != 24'd0) && (r_pcnt == r_period - 24'd1) && !w_wr_period;

   pad_frame_engine #(
      .NUM_CH    (NUM_CH),
      .BITS      (BITS),
      .CLK_DIV   (CLK_DIV),
      .LATCH_CYC (LATCH_CYC),
      .INVERT    (INVERT)
   ) u_engine (
      .clk       (PCLK),
      .rst_n     (PRESERN),
      .i_trigger (w_start | w_tick),
      .i_data    (data),
      .o_poll    (poll),
      .o_sclk    (sclk),
      .o_commit  (w_commit),
      .o_busy    (w_busy),
      .o_shift   (w_shift)
   );

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         r_auto   <= 1'b0;
         r_irq_en <= 1'b0;
         r_period <= POLL_DEFAULT;
         r_pcnt   <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_auto   <= bus.PWDATA[CTRL_AUTO];
            r_irq_en <= bus.PWDATA[CTRL_IRQ_EN];
         end
         if (w_wr_period) r_period <= bus.PWDATA[23:0];

         if (!r_auto || w_wr_period) r_pcnt <= '0;
         else if (r_period != 24'd0) r_pcnt <= w_tick ? 24'd0 : r_pcnt + 24'd1;
      end
   end

   // Commit is applied after the W1C so a same-cycle set beats the clear
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         r_done <= 1'b0;
         r_ovr  <= 1'b0;
         r_data <= '0;
      end else begin
         if (w_wr_status) begin
            if (bus.PWDATA[STAT_DONE])    r_done <= 1'b0;
            if (bus.PWDATA[STAT_OVERRUN]) r_ovr  <= 1'b0;
         end
         if (w_commit) begin
            r_data <= w_shift;
            r_done <= 1'b1;
            if (r_done) r_ovr <= 1'b1;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      w_valid = 1'b0;
      case (w_idx)
         IDX_CTRL: begin
            w_valid = 1'b1;
            w_rdata[CTRL_AUTO]   = r_auto;
            w_rdata[CTRL_IRQ_EN] = r_irq_en;
         end
         IDX_STATUS: begin
            w_valid = 1'b1;
            w_rdata[STAT_BUSY]    = w_busy;
            w_rdata[STAT_DONE]    = r_done;
            w_rdata[STAT_OVERRUN] = r_ovr;
         end
         IDX_PERIOD: begin
            w_valid = 1'b1;
            w_rdata = {8'd0, r_period};
         end
         default: begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (w_idx == 6'(IDX_DATA0 + c)) begin
                  w_valid = 1'b1;
                  w_rdata = 32'(r_data[c]);
               end
            end
         end
      endcase
   end

   assign bus.PRDATA  = w_rdata;
   assign bus.PREADY  = 1'b1;
   assign bus.PSLVERR = w_acc & ~w_valid;

   assign ready      = w_commit;
   assign irq        = r_done & r_irq_en;
   assign buttonData = r_data[0];

endmodule

// File: tb/tb_apb_pad_reader.sv
// Scoreboard bench for apb_pad_reader: pad shift-register model, APB driver, ready monitor.
module tb_apb_pad_reader;

   localparam int          NUM_CH       = 2;
   localparam int          BITS         = 8;
   localparam int          CLK_DIV      = 2;
   localparam int          LATCH_CYC    = 3;
   localparam int          INVERT       = 1;
   localparam logic [23:0] POLL_DEFAULT = 24'd400000;
   localparam int          FRAME        = LATCH_CYC + 2 * BITS * CLK_DIV + 1;

   logic                PCLK = 1'b0;
   logic                PRESERN = 1'b0;
   logic [NUM_CH-1:0]   data;
   logic                poll, sclk, ready, irq;
   logic [BITS-1:0]     buttonData;

   apb_pad_reader_if bus();

   apb_pad_reader #(
      .NUM_CH       (NUM_CH),
      .BITS         (BITS),
      .CLK_DIV      (CLK_DIV),
      .LATCH_CYC    (LATCH_CYC),
      .INVERT       (INVERT),
      .POLL_DEFAULT (POLL_DEFAULT)
   ) dut (
      .PCLK       (PCLK),
      .PRESERN    (PRESERN),
      .bus        (bus),
      .data       (data),
      .poll       (poll),
      .sclk       (sclk),
      .ready      (ready),
      .irq        (irq),
      .buttonData (buttonData)
   );

   always #5 PCLK = ~PCLK;

   int unsigned cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Pad model: parallel load on latch, next bit presented on each sclk rising edge
   logic [BITS-1:0] pad_val [NUM_CH];
   logic [BITS-1:0] pad_sr  [NUM_CH];

   always @(posedge poll) for (int c = 0; c < NUM_CH; c++) pad_sr[c] = pad_val[c];
   always @(posedge sclk) for (int c = 0; c < NUM_CH; c++) pad_sr[c] = {1'b1, pad_sr[c][BITS-1:1]};
   always_comb begin
      data = '0;
      for (int c = 0; c < NUM_CH; c++) data[c] = pad_sr[c][0];
   end

   function automatic logic [NUM_CH-1:0][BITS-1:0] expect_frame();
      logic [NUM_CH-1:0][BITS-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c] = (INVERT != 0) ? ~pad_val[c] : pad_val[c];
      return r;
   endfunction

   typedef struct {
      int unsigned                 cyc;
      logic [NUM_CH-1:0][BITS-1:0] d;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   logic pend_vld = 1'b0;
   int   sclk_pulses = 0;
   int   sclk_hi = 0;

   always @(posedge sclk) sclk_pulses++;

   always @(negedge PCLK) begin
      if (!PRESERN) begin
         sclk_pulses = 0;
         sclk_hi     = 0;
         pend_vld    = 1'b0;
      end else begin
         if (sclk) sclk_hi++;
         if (pend_vld) begin
            check("buttonData", 32'(buttonData), 32'(mon_e.d[0]));
            pend_vld = 1'b0;
         end
         if (ready) begin
            check("ready_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               check("ready_cycle", cyc, mon_e.cyc);
               check("sclk_pulses", sclk_pulses, BITS);
               check("sclk_high_cycles", sclk_hi, BITS * CLK_DIV);
               pend_vld = 1'b1;
            end
            sclk_pulses = 0;
            sclk_hi     = 0;
         end
      end
   end

   task automatic apb_write(input logic [31:0] a, input logic [31:0] d,
                            output int unsigned t, output logic err);
      @(posedge PCLK); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      t = cyc;
      @(negedge PCLK);
      err = bus.PSLVERR;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
      @(posedge PCLK); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      @(negedge PCLK);
      d   = bus.PRDATA;
      err = bus.PSLVERR;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      apb_read(a, d, e);
      check(name, d, exp);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge PCLK);
         n++;
      end
      check(name, sb_q.size(), 0);
      repeat (2) @(posedge PCLK);
   endtask

   initial begin
      int unsigned                 t, t2;
      logic                        err;
      logic [31:0]                 rd;
      logic [NUM_CH-1:0][BITS-1:0] ef;
      int                          n;

      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0; bus.PWDATA = '0;
      for (int c = 0; c < NUM_CH; c++) pad_val[c] = '0;

      // Reset values
      PRESERN = 1'b0;
      repeat (3) @(posedge PCLK);
      #1;
      check("rst_poll", 32'(poll), 0);
      check("rst_sclk", 32'(sclk), 0);
      check("rst_ready", 32'(ready), 0);
      check("rst_irq", 32'(irq), 0);
      @(negedge PCLK) PRESERN = 1'b1;
      read_check("rst_period", 32'h08, 32'(POLL_DEFAULT));
      read_check("rst_data0", 32'h10, 0);
      read_check("rst_ctrl", 32'h00, 0);
      read_check("rst_status", 32'h04, 0);

      // Manual frame with the reference pattern
      pad_val[0] = 8'hA5; pad_val[1] = 8'h00;
      ef = expect_frame();
      apb_write(32'h00, 32'h2, t, err);
      sb_q.push_back('{t + FRAME, ef});
      wait_drain("manual_drain", 4 * FRAME);
      read_check("manual_data0", 32'h10, 32'h5A);
      read_check("manual_data1", 32'h14, 32'hFF);
      check("manual_buttonData", 32'(buttonData), 32'h5A);
      read_check("manual_status", 32'h04, 32'h2);
      check("manual_irq_masked", 32'(irq), 0);
      apb_write(32'h04, 32'h6, t, err);

      // Random pad patterns
      for (int i = 0; i < 4; i++) begin
         for (int c = 0; c < NUM_CH; c++) pad_val[c] = 8'($urandom);
         ef = expect_frame();
         apb_write(32'h00, 32'h2, t, err);
         sb_q.push_back('{t + FRAME, ef});
         wait_drain("rand_drain", 4 * FRAME);
         read_check("rand_data0", 32'h10, 32'(ef[0]));
         read_check("rand_data1", 32'h14, 32'(ef[1]));
         apb_write(32'h04, 32'h6, t, err);
      end

      // Start while busy is dropped
      for (int c = 0; c < NUM_CH; c++) pad_val[c] = 8'($urandom);
      ef = expect_frame();
      apb_write(32'h00, 32'h2, t, err);
      sb_q.push_back('{t + FRAME, ef});
      repeat (5) @(posedge PCLK);
      apb_read(32'h04, rd, err);
      check("busy_flag", 32'(rd[0]), 1);
      apb_write(32'h00, 32'h2, t2, err);
      wait_drain("busy_drain", 4 * FRAME);
      repeat (FRAME + 10) @(posedge PCLK);
      apb_write(32'h04, 32'h6, t, err);

      // Unmapped offsets
      apb_read(32'h40, rd, err);
      check("err40_rd_slverr", 32'(err), 1);
      check("err40_rd_data", rd, 0);
      apb_read(32'h18, rd, err);
      check("err18_rd_slverr", 32'(err), 1);
      check("err18_rd_data", rd, 0);
      apb_write(32'h40, 32'hFFFF_FFFF, t, err);
      check("err40_wr_slverr", 32'(err), 1);
      apb_write(32'h18, 32'hFFFF_FFFF, t, err);
      check("err18_wr_slverr", 32'(err), 1);
      read_check("err_ctrl_kept", 32'h00, 0);
      read_check("err_period_kept", 32'h08, 32'(POLL_DEFAULT));
      read_check("err_status_kept", 32'h04, 0);

      // Auto polling every 50 cycles, irq and overrun
      pad_val[0] = 8'($urandom_range(0, 254));
      pad_val[1] = 8'($urandom);
      ef = expect_frame();
      apb_write(32'h08, 32'd50, t, err);
      apb_write(32'h00, 32'h5, t, err);
      sb_q.push_back('{t + 50 + FRAME, ef});
      sb_q.push_back('{t + 100 + FRAME, ef});
      n = 0;
      while (sb_q.size() > 1 && n < 200) begin
         @(posedge PCLK);
         n++;
      end
      check("auto_first_frame", 32'(sb_q.size()), 1);
      @(negedge PCLK);
      check("auto_irq_set", 32'(irq), 1);
      read_check("auto_status_first", 32'h04, 32'h2);
      wait_drain("auto_drain", 200);
      apb_write(32'h00, 32'h4, t, err);
      read_check("auto_status_overrun", 32'h04, 32'h6);
      check("auto_irq_held", 32'(irq), 1);
      apb_write(32'h04, 32'h6, t, err);
      read_check("auto_status_cleared", 32'h04, 0);
      check("auto_irq_cleared", 32'(irq), 0);
      repeat (120) @(posedge PCLK);

      // Reset in the middle of a frame
      for (int c = 0; c < NUM_CH; c++) pad_val[c] = 8'($urandom);
      apb_write(32'h00, 32'h2, t, err);
      n = 0;
      while (!sclk && n < 100) begin
         @(negedge PCLK);
         n++;
      end
      check("midrst_sclk_seen", 32'(sclk), 1);
      #1 PRESERN = 1'b0;
      #1;
      check("midrst_sclk_low", 32'(sclk), 0);
      check("midrst_poll_low", 32'(poll), 0);
      check("midrst_ready_low", 32'(ready), 0);
      repeat (2) @(posedge PCLK);
      @(negedge PCLK) PRESERN = 1'b1;
      read_check("midrst_data0", 32'h10, 0);
      read_check("midrst_data1", 32'h14, 0);
      read_check("midrst_status", 32'h04, 0);
      repeat (FRAME + 10) @(posedge PCLK);

      check("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
